// File: rtl/apb_chk_pkg.sv
// Shared types for the APB protocol checker: violation classes, FSM phases
// and the first-violation priority helper.
package apb_chk_pkg;

    localparam int NUM_VIOL = 8;

    typedef enum logic [2:0] {
        V_MULTI_SEL  = 3'd0,
        V_SETUP_VIOL = 3'd1,
        V_EN_NO_SEL  = 3'd2,
        V_UNSTABLE   = 3'd3,
        V_EN_MISSING = 3'd4,
        V_TIMEOUT    = 3'd5,
        V_BAD_SLVERR = 3'd6,
        V_SEL_DROP   = 3'd7
    } viol_e;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SETUP = 2'd1,
        WAIT  = 2'd2
    } state_e;

    // Lowest set class index wins when several classes fire together.
    function automatic viol_e lowest_viol(input logic [NUM_VIOL-1:0] v);
        viol_e r;
        r = V_MULTI_SEL;
        for (int i = NUM_VIOL - 1; i >= 0; i--) begin
            if (v[i]) r = viol_e'(3'(i));
        end
        return r;
    endfunction

endpackage

// File: rtl/apb_protocol_checker_if.sv
// APB bus bundle: requester drives selects/controls, completer drives
// ready/error, and a monitor view observes everything.
interface apb_protocol_checker_if #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int NUM_SEL = 4
);
    logic [NUM_SEL-1:0] PSEL;
    logic               PENABLE;
    logic               PWRITE;
    logic [ADDR_W-1:0]  PADDR;
    logic [DATA_W-1:0]  PWDATA;
    logic               PREADY;
    logic               PSLVERR;

    modport master  (output PSEL, PENABLE, PWRITE, PADDR, PWDATA, input PREADY, PSLVERR);
    modport slave   (input PSEL, PENABLE, PWRITE, PADDR, PWDATA, output PREADY, PSLVERR);
    modport monitor (input PSEL, PENABLE, PWRITE, PADDR, PWDATA, PREADY, PSLVERR);
endinterface

// File: rtl/apb_chk_recorder.sv
// Turns the per-cycle violation vector into registered pulses, sticky flags,
// a saturating counter, first-violation capture and the interrupt.
module apb_chk_recorder
    import apb_chk_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int CNT_W  = 8
) (
    input  logic                clk,
    input  logic                srst,
    input  logic                clr,
    input  logic [NUM_VIOL-1:0] viol,
    input  logic [ADDR_W-1:0]   addr,
    input  logic [NUM_VIOL-1:0] irq_mask,
    output logic [NUM_VIOL-1:0] viol_o,
    output logic [NUM_VIOL-1:0] viol_sticky_o,
    output logic [CNT_W-1:0]    viol_cnt_o,
    output logic                first_valid_o,
    output logic [2:0]          first_code_o,
    output logic [ADDR_W-1:0]   first_addr_o,
    output logic                irq_o
);
    logic [NUM_VIOL-1:0] viol_reg, sticky_reg;
    logic [CNT_W-1:0]    cnt_reg, cnt_base, cnt_next;
    logic                first_valid_reg, first_base;
    viol_e               first_code_reg;
    logic [ADDR_W-1:0]   first_addr_reg;
    logic                irq_reg;
    logic                any_viol;

    assign any_viol   = |viol;
    // Clear is applied first so a same-cycle violation still gets recorded.
    assign first_base = clr ? 1'b0 : first_valid_reg;

    always_comb begin
        cnt_base = clr ? '0 : cnt_reg;
        cnt_next = cnt_base;
        if (any_viol && (cnt_base != '1)) cnt_next = cnt_base + CNT_W'(1);
    end

    always_ff @(posedge clk) begin
        if (srst) begin
            viol_reg        <= '0;
            sticky_reg      <= '0;
            cnt_reg         <= '0;
            first_valid_reg <= 1'b0;
            first_code_reg  <= V_MULTI_SEL;
            first_addr_reg  <= '0;
            irq_reg         <= 1'b0;
        end else begin
            viol_reg   <= viol;
            sticky_reg <= (clr ? '0 : sticky_reg) | viol;
            cnt_reg    <= cnt_next;
            irq_reg    <= |(sticky_reg & irq_mask);
            if (!first_base && any_viol) begin
                first_valid_reg <= 1'b1;
                first_code_reg  <= lowest_viol(viol);
                first_addr_reg  <= addr;
            end else if (clr) begin
                first_valid_reg <= 1'b0;
                first_code_reg  <= V_MULTI_SEL;
                first_addr_reg  <= '0;
            end
        end
    end

    assign viol_o        = viol_reg;
    assign viol_sticky_o = sticky_reg;
    assign viol_cnt_o    = cnt_reg;
    assign first_valid_o = first_valid_reg;
    assign first_code_o  = first_code_reg;
    assign first_addr_o  = first_addr_reg;
    assign irq_o         = irq_reg;
endmodule

// File: rtl/apb_protocol_checker.sv
// Passive APB monitor: tracks the previous cycle's phase, latches setup
// values and classifies each cycle into eight violation classes.
module apb_protocol_checker
    import apb_chk_pkg::*;
#(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int NUM_SEL = 4,
    parameter int TIMEOUT = 16,
    parameter int CNT_W   = 8
) (
    input  logic                    PCLK,
    input  logic                    PRESET,
    apb_protocol_checker_if.monitor bus,
    input  logic                    clr_i,
    input  logic [NUM_VIOL-1:0]     irq_mask_i,
    output logic [NUM_VIOL-1:0]     viol_o,
    output logic [NUM_VIOL-1:0]     viol_sticky_o,
    output logic [CNT_W-1:0]        viol_cnt_o,
    output logic                    first_valid_o,
    output logic [2:0]              first_code_o,
    output logic [ADDR_W-1:0]       first_addr_o,
    output logic                    irq_o
);
    localparam int             WC_W = $clog2(TIMEOUT + 1);
    localparam logic [WC_W-1:0] WC_MAX = WC_W'(TIMEOUT);

    state_e              state_reg, state_next;
    logic [NUM_SEL-1:0]  sel_lat_reg;
    logic [ADDR_W-1:0]   addr_lat_reg;
    logic                write_lat_reg;
    logic [DATA_W-1:0]   wdata_lat_reg;
    logic [WC_W-1:0]     wait_cnt_reg, wait_cnt_next;
    logic                latch_en;
    logic                sel_any, mismatch;
    logic [NUM_VIOL-1:0] viol_next;

    assign sel_any  = |bus.PSEL;
    assign mismatch = (bus.PSEL != sel_lat_reg) || (bus.PADDR != addr_lat_reg) ||
                      (bus.PWRITE != write_lat_reg) ||
                      (bus.PWRITE && (bus.PWDATA != wdata_lat_reg));

    always_comb begin
        state_next    = state_reg;
        wait_cnt_next = wait_cnt_reg;
        latch_en      = 1'b0;
        viol_next     = '0;
        // Class 0/2/6 depend only on the current cycle, not the phase.
        viol_next[V_MULTI_SEL]  = (bus.PSEL & (bus.PSEL - NUM_SEL'(1))) != '0;
        viol_next[V_EN_NO_SEL]  = bus.PENABLE && !sel_any;
        viol_next[V_BAD_SLVERR] = bus.PSLVERR && !(sel_any && bus.PENABLE && bus.PREADY);
        if (state_reg == IDLE) begin
            if (sel_any) begin
                latch_en      = 1'b1;
                wait_cnt_next = '0;
                if (!bus.PENABLE) begin
                    state_next = SETUP;
                end else begin
                    viol_next[V_SETUP_VIOL] = 1'b1;
                    if (bus.PREADY) begin
                        state_next = IDLE;
                    end else begin
                        state_next             = WAIT;
                        wait_cnt_next          = WC_W'(1);
                        viol_next[V_TIMEOUT]   = (TIMEOUT == 1);
                    end
                end
            end
        end else if (!sel_any) begin
            viol_next[V_SEL_DROP] = 1'b1;
            state_next            = IDLE;
            wait_cnt_next         = '0;
        end else if (!bus.PENABLE) begin
            viol_next[V_EN_MISSING] = 1'b1;
            latch_en                = 1'b1;
            state_next              = SETUP;
            wait_cnt_next           = '0;
        end else begin
            viol_next[V_UNSTABLE] = mismatch;
            if (bus.PREADY) begin
                state_next    = IDLE;
                wait_cnt_next = '0;
            end else begin
                state_next = WAIT;
                // Saturating at the limit keeps the timeout to one pulse per transfer.
                if (wait_cnt_reg != WC_MAX) begin
                    wait_cnt_next        = wait_cnt_reg + WC_W'(1);
                    viol_next[V_TIMEOUT] = (wait_cnt_reg + WC_W'(1)) == WC_MAX;
                end
            end
        end
    end

    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            state_reg     <= IDLE;
            wait_cnt_reg  <= '0;
            sel_lat_reg   <= '0;
            addr_lat_reg  <= '0;
            write_lat_reg <= 1'b0;
            wdata_lat_reg <= '0;
        end else begin
            state_reg    <= state_next;
            wait_cnt_reg <= wait_cnt_next;
            if (latch_en) begin
                sel_lat_reg   <= bus.PSEL;
                addr_lat_reg  <= bus.PADDR;
                write_lat_reg <= bus.PWRITE;
                wdata_lat_reg <= bus.PWDATA;
            end
        end
    end

    apb_chk_recorder #(
        .ADDR_W (ADDR_W),
        .CNT_W  (CNT_W)
    ) u_recorder (
        .clk           (PCLK),
        .srst          (PRESET),
        .clr           (clr_i),
        .viol          (viol_next),
        .addr          (bus.PADDR),
        .irq_mask      (irq_mask_i),
        .viol_o        (viol_o),
        .viol_sticky_o (viol_sticky_o),
        .viol_cnt_o    (viol_cnt_o),
        .first_valid_o (first_valid_o),
        .first_code_o  (first_code_o),
        .first_addr_o  (first_addr_o),
        .irq_o         (irq_o)
    );
endmodule

// File: tb/tb_apb_protocol_checker.sv
// Directed bench for apb_protocol_checker with a cycle-level reference model
// derived from the protocol rules and literal spot checks.
module tb_apb_protocol_checker;
    localparam int ADDR_W = 32, DATA_W = 32, NUM_SEL = 4, TIMEOUT = 16, CNT_W = 8;

    logic PCLK = 1'b0;
    logic PRESET;
    logic [NUM_SEL-1:0] psel;
    logic pen, pwr, pready, pslverr, clr;
    logic [ADDR_W-1:0] paddr;
    logic [DATA_W-1:0] pwdata;
    logic [7:0] mask;

    logic [7:0]        viol_o, viol_sticky_o;
    logic [CNT_W-1:0]  viol_cnt_o;
    logic              first_valid_o, irq_o;
    logic [2:0]        first_code_o;
    logic [ADDR_W-1:0] first_addr_o;

    int checks = 0;
    int errors = 0;

    // Reference model state
    int          m_phase;   // 0 idle, 1 setup, 2 wait
    int          m_waits;
    logic [NUM_SEL-1:0] m_sel;
    logic [ADDR_W-1:0]  m_addr;
    logic               m_wr;
    logic [DATA_W-1:0]  m_wdata;
    logic [7:0]  m_viol, m_sticky;
    int          m_cnt, m_fc;
    logic        m_fv, m_irq;
    logic [ADDR_W-1:0] m_fa;

    apb_protocol_checker_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .NUM_SEL(NUM_SEL)) bus ();
    assign bus.PSEL    = psel;
    assign bus.PENABLE = pen;
    assign bus.PWRITE  = pwr;
    assign bus.PADDR   = paddr;
    assign bus.PWDATA  = pwdata;
    assign bus.PREADY  = pready;
    assign bus.PSLVERR = pslverr;

    apb_protocol_checker #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .NUM_SEL(NUM_SEL), .TIMEOUT(TIMEOUT), .CNT_W(CNT_W)
    ) dut (
        .PCLK          (PCLK),
        .PRESET        (PRESET),
        .bus           (bus),
        .clr_i         (clr),
        .irq_mask_i    (mask),
        .viol_o        (viol_o),
        .viol_sticky_o (viol_sticky_o),
        .viol_cnt_o    (viol_cnt_o),
        .first_valid_o (first_valid_o),
        .first_code_o  (first_code_o),
        .first_addr_o  (first_addr_o),
        .irq_o         (irq_o)
    );

    always #5 PCLK = ~PCLK;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        m_phase = 0; m_waits = 0; m_sel = '0; m_addr = '0; m_wr = 0; m_wdata = '0;
        m_viol = '0; m_sticky = '0; m_cnt = 0; m_fc = 0; m_fv = 0; m_fa = '0; m_irq = 0;
    endtask

    // Predict this cycle's outcome, clock it in, then compare every output.
    task automatic cycle();
        logic [7:0] v;
        bit sa;
        if (PRESET) begin
            model_reset();
        end else begin
            v  = '0;
            sa = (psel != 0);
            if ($countones(psel) > 1) v[0] = 1;
            if (pen && !sa) v[2] = 1;
            if (pslverr && !(sa && pen && pready)) v[6] = 1;
            if (m_phase == 0) begin
                if (sa) begin
                    m_sel = psel; m_addr = paddr; m_wr = pwr; m_wdata = pwdata; m_waits = 0;
                    if (!pen) m_phase = 1;
                    else begin
                        v[1] = 1;
                        if (pready) m_phase = 0;
                        else begin m_phase = 2; m_waits++; if (m_waits == TIMEOUT) v[5] = 1; end
                    end
                end
            end else if (!sa) begin
                v[7] = 1; m_phase = 0; m_waits = 0;
            end else if (!pen) begin
                v[4] = 1; m_phase = 1; m_waits = 0;
                m_sel = psel; m_addr = paddr; m_wr = pwr; m_wdata = pwdata;
            end else begin
                if (psel != m_sel || paddr != m_addr || pwr != m_wr || (pwr && pwdata != m_wdata)) v[3] = 1;
                if (pready) begin m_phase = 0; m_waits = 0; end
                else begin m_phase = 2; m_waits++; if (m_waits == TIMEOUT) v[5] = 1; end
            end
            m_irq = |(m_sticky & mask);
            if (clr) begin m_sticky = '0; m_cnt = 0; m_fv = 0; m_fc = 0; m_fa = '0; end
            m_viol = v;
            if (v != 0) begin
                m_sticky |= v;
                if (m_cnt < 255) m_cnt++;
                if (!m_fv) begin
                    m_fv = 1; m_fa = paddr;
                    for (int i = 7; i >= 0; i--) if (v[i]) m_fc = i;
                end
            end
        end
        @(posedge PCLK);
        #1;
        chk("viol", 64'(viol_o), 64'(m_viol));
        chk("sticky", 64'(viol_sticky_o), 64'(m_sticky));
        chk("cnt", 64'(viol_cnt_o), 64'(m_cnt));
        chk("first_valid", 64'(first_valid_o), 64'(m_fv));
        chk("first_code", 64'(first_code_o), 64'(m_fc));
        chk("first_addr", 64'(first_addr_o), 64'(m_fa));
        chk("irq", 64'(irq_o), 64'(m_irq));
    endtask

    task automatic idle(input int n);
        psel = '0; pen = 0; pready = 0; pslverr = 0;
        for (int i = 0; i < n; i++) cycle();
    endtask

    task automatic do_clr();
        clr = 1; idle(1); clr = 0;
    endtask

    int t5;

    initial begin
        PRESET = 1; psel = '0; pen = 0; pwr = 0; pready = 0; pslverr = 0; clr = 0;
        paddr = '0; pwdata = '0; mask = 8'h00;
        model_reset();
        cycle(); cycle();
        PRESET = 0;
        chk("reset_viol", 64'(viol_o), 64'h0);
        chk("reset_cnt", 64'(viol_cnt_o), 64'h0);
        chk("reset_irq", 64'(irq_o), 64'h0);

        // Clean write followed back-to-back by a clean read
        $display("tx: write 0x10 <= 0xA5");
        psel = 4'b0001; pen = 0; pwr = 1; paddr = 32'h10; pwdata = 32'hA5; cycle();
        pen = 1; pready = 1; cycle();
        $display("tx: back-to-back read 0x14");
        pen = 0; pwr = 0; paddr = 32'h14; cycle();
        pen = 1; cycle();
        idle(1);
        chk("clean_cnt", 64'(viol_cnt_o), 64'h0);
        chk("clean_sticky", 64'(viol_sticky_o), 64'h0);

        // Setup skipped: PSEL and PENABLE rise together
        $display("tx: setup violation at 0x40");
        mask = 8'h02;
        psel = 4'b0001; pen = 1; pready = 1; paddr = 32'h40; cycle();
        chk("setup_viol", 64'(viol_o), 64'h02);
        chk("setup_code", 64'(first_code_o), 64'd1);
        chk("setup_addr", 64'(first_addr_o), 64'h40);
        idle(1);
        chk("setup_irq", 64'(irq_o), 64'h1);
        mask = 8'hFF;
        do_clr();

        // Timeout on a 16-cycle stall, then a 3-wait transfer without one
        $display("tx: stalled read 0x80");
        t5 = 0;
        psel = 4'b0010; pen = 0; pwr = 0; paddr = 32'h80; cycle();
        pen = 1; pready = 0;
        for (int i = 0; i < 16; i++) begin cycle(); t5 += int'(viol_o[5]); end
        chk("timeout_pulse", 64'(viol_o), 64'h20);
        for (int i = 0; i < 4; i++) begin cycle(); t5 += int'(viol_o[5]); end
        pready = 1; cycle();
        chk("timeout_once", 64'(t5), 64'd1);
        $display("tx: read 0x84 with 3 waits");
        pen = 0; paddr = 32'h84; cycle();
        pen = 1; pready = 0;
        for (int i = 0; i < 3; i++) cycle();
        pready = 1; cycle();
        chk("no_timeout", 64'(viol_o[5]), 64'h0);
        idle(1);
        do_clr();

        // Address and select change during wait
        $display("tx: unstable read 0x20");
        psel = 4'b0001; pen = 0; pwr = 0; paddr = 32'h20; cycle();
        pen = 1; pready = 0; cycle();
        paddr = 32'h24; psel = 4'b0011; cycle();
        chk("unstable_viol", 64'(viol_o), 64'h09);
        chk("unstable_code", 64'(first_code_o), 64'd0);
        pready = 1; cycle();
        idle(1);
        do_clr();

        // Select dropped after setup, then clear with a stray PSLVERR
        $display("tx: select drop at 0x50");
        psel = 4'b0100; pen = 0; paddr = 32'h50; cycle();
        psel = 4'b0000; cycle();
        chk("drop_viol", 64'(viol_o), 64'h80);
        clr = 1; pslverr = 1; cycle();
        clr = 0; pslverr = 0;
        chk("clr_set_sticky", 64'(viol_sticky_o), 64'h40);
        chk("clr_set_cnt", 64'(viol_cnt_o), 64'd1);
        chk("clr_set_code", 64'(first_code_o), 64'd6);

        // Counter saturation
        $display("tx: 300 enable-without-select cycles");
        psel = '0; pen = 1;
        for (int i = 0; i < 300; i++) cycle();
        chk("cnt_sat", 64'(viol_cnt_o), 64'd255);

        // Reset in the middle of a wait
        $display("tx: reset during wait at 0x30");
        idle(1);
        psel = 4'b1000; pen = 0; paddr = 32'h30; cycle();
        pen = 1; pready = 0; cycle();
        PRESET = 1; cycle();
        PRESET = 0;
        chk("rst_sticky", 64'(viol_sticky_o), 64'h0);
        chk("rst_cnt", 64'(viol_cnt_o), 64'h0);
        chk("rst_first", 64'(first_valid_o), 64'h0);
        pready = 1; cycle();
        chk("post_rst_viol", 64'(viol_o), 64'h02);
        idle(2);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/apb_protocol_checker.md
Name: apb_protocol_checker

Overview:
- Passive, synthesizable APB bus-protocol checker that sits beside an APB slave interface, with NUM_SEL select lines.
- Tracks transfer phases per cycle and flags eight classes of protocol violation, including the PSEL setup violation.
- Keeps per-class sticky flags, a saturating violation counter and first-violation capture (code plus address).
- Drives an interrupt; used in silicon debug and as a self-checking monitor in the APB environment.

Parameters:
- ADDR_W, 32, PADDR width
- DATA_W, 32, PWDATA width
- NUM_SEL, 4, number of PSEL lines (slaves)
- TIMEOUT, 16, maximum PREADY-low access cycles before a timeout flag (>=1)
- CNT_W, 8, violation counter width

Ports:
- PCLK  in  1  clock
- PRESET  in  1  synchronous active-high reset
- PSEL  in  NUM_SEL  slave selects
- PENABLE  in  1  enable
- PWRITE  in  1  direction
- PADDR  in  ADDR_W  address
- PWDATA  in  DATA_W  write data
- PREADY  in  1  slave ready
- PSLVERR  in  1  slave error
- clr_i  in  1  clear sticky flags, counter and first capture
- irq_mask_i  in  8  per-class interrupt enable
- viol_o  out  8  per-class pulse, registered
- viol_sticky_o  out  8  sticky per-class flags
- viol_cnt_o  out  CNT_W  saturating count of cycles with any violation
- first_valid_o  out  1  first capture valid
- first_code_o  out  3  class of first violation (lowest index wins on a tie)
- first_addr_o  out  ADDR_W  PADDR in the first-violation cycle
- irq_o  out  1  OR of (viol_sticky_o AND irq_mask_i), registered

Behaviour:
- Interface: one clock PCLK; reset PRESET is synchronous and active-high.
- Reset: all outputs 0, FSM in IDLE, latches and wait counter 0.
- sel_any = OR of PSEL.
- Violation classes:
  - 0 MULTI_SEL: more than one PSEL bit high, any cycle.
  - 1 SETUP_VIOL: PSEL rises from IDLE with PENABLE=1.
  - 2 EN_NO_SEL: PENABLE=1 with sel_any=0.
  - 3 UNSTABLE: PSEL, PADDR or PWRITE (and PWDATA when PWRITE=1) differ from the setup-latched values in an access cycle.
  - 4 EN_MISSING: a cycle after SETUP/WAIT has sel_any=1 and PENABLE=0.
  - 5 TIMEOUT: TIMEOUT consecutive access cycles with PREADY=0; pulses once per transfer.
  - 6 BAD_SLVERR: PSLVERR=1 while not (sel_any AND PENABLE AND PREADY).
  - 7 SEL_DROP: sel_any=0 in the cycle after SETUP/WAIT.
- FSM state records the phase of the previous cycle: IDLE, SETUP, WAIT.
  - IDLE, sel_any=1:
    - Latch PSEL, PADDR, PWRITE, PWDATA.
    - PENABLE=0 -> SETUP.
    - PENABLE=1 -> flag 1; the cycle counts as an access: PREADY=1 -> IDLE, else WAIT with wait counter 1.
  - IDLE, sel_any=0: stay; flag 2 if PENABLE=1.
  - SETUP/WAIT, sel_any=0: flag 7 -> IDLE (flag 2 also if PENABLE=1).
  - SETUP/WAIT, sel_any=1, PENABLE=0: flag 4; re-latch signals; -> SETUP.
  - SETUP/WAIT, sel_any=1, PENABLE=1 (access): compare against latches, flag 3 on mismatch (latches not updated).
    - PREADY=1 -> IDLE; counter cleared.
    - PREADY=0 -> WAIT; counter increments (saturates at TIMEOUT); flag 5 when it reaches TIMEOUT.
- Back-to-back transfers: completion returns to IDLE and the next cycle may start a new setup with no idle cycle.
- Latency: detection in cycle N appears on viol_o/sticky/count/first at the edge ending N, i.e. visible in N+1; irq_o one cycle later.
- viol_cnt_o increments by 1 per cycle with any flag and saturates at all-ones.
- first_* is captured only while first_valid_o=0.
- clr_i and a violation in the same cycle: clear applies, then that cycle's violation is recorded (set wins).
- PRESET mid-transfer: FSM to IDLE; the next PENABLE=1 without a setup cycle is flagged 1 or 2 normally.

Decomposition:
- apb_chk_pkg holds:
  - viol_e enum with codes 0-7
  - NUM_VIOL=8
  - state_e {IDLE, SETUP, WAIT}
- Sub-module apb_chk_recorder: takes the 8-bit per-cycle violation vector and the address; owns sticky flags, counter, first capture and irq.
- Top holds the FSM, latches and wait counter.

Test Plan:
- Write 0x10/0xA5, correct setup then access, PREADY=1: no flags, viol_cnt_o=0.
- PSEL=0001 with PENABLE=1 in the same cycle from IDLE, PADDR=0x40: viol_o[1] pulses; first_code_o=1; first_addr_o=0x40; irq_o=1 with mask 0x02.
- Access with PREADY held low 16 cycles (TIMEOUT=16): single viol_o[5] pulse; no flag 5 on a second transfer that completes in 3 wait cycles.
- PADDR changes 0x20->0x24 during a WAIT cycle: flag 3; PSEL=0011: flag 0 in the same cycle; first_code_o=0.
- PSEL dropped after setup: flag 7, state IDLE. Then clr_i together with PSLVERR=1 while idle: sticky=0x40, cnt=1, first_code_o=6.
- 300 consecutive EN_NO_SEL cycles (CNT_W=8): viol_cnt_o saturates at 255. PRESET mid-WAIT clears all outputs.
